collision_endgame_fsm: RTL and testbench
========================================

# collision_endgame_fsm

Frame-rate game-state controller downstream of the collision probe scanner. It samples the eight 3-bit tile codes under the Fireboy and Watergirl probes once per frame. From them it produces per-character blocked flags, and it decides death and level-complete outcomes with persistence filtering. Its outputs drive the movement controllers (blocked/freeze) and the overlay/menu logic (state, win progress).

## Interface
- HAZARD_FRAMES, 2: consecutive frames a lethal tile must persist before death (1..15)
- WIN_FRAMES, 30: consecutive frames both characters must stand in their doors (1..63)
- vga_clk  in  1  pixel clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (VSYNC start); probe sample strobe
- start  in  1  one-cycle pulse, leave title screen
- restart  in  1  one-cycle pulse, restart level from terminal state
- fLeft, fRight, fTop, fBottom  in  3 each  Fireboy probe tile codes
- wLeft, wRight, wTop, wBottom  in  3 each  Watergirl probe tile codes
- f_blk_l, f_blk_r, f_blk_u, f_grounded  out  1 each  Fireboy blocked flags
- w_blk_l, w_blk_r, w_blk_u, w_grounded  out  1 each  Watergirl blocked flags
- game_state  out  3  IDLE=0, PLAY=1, WIN=2, DEAD_FIRE=3, DEAD_WATER=4, DEAD_BOTH=5
- freeze  out  1  high in every state except PLAY
- win_progress  out  6  current door-occupancy frame count

## Operation
- Tile codes: 0 empty, 1 wall, 2 lava, 3 water pool, 4 green goo, 5 fire door, 6 water door, 7 reserved (treated as empty).
- Blocked flags are registered on frame_tick in every state. A flag is 1 when its probe code == 1; otherwise 0. Between ticks the flags hold.
- Lethal to Fireboy: fBottom ∈ {3,4}. Lethal to Watergirl: wBottom ∈ {2,4}. Top, left and right probes are never lethal.
- In-door: Fireboy when any of fLeft/fRight/fBottom == 5; Watergirl when any of wLeft/wRight/wBottom == 6.
- Counters f_haz, w_haz (4 bit) and win_cnt (6 bit) update only on frame_tick in PLAY:
  - f_haz: increments if Fireboy is on a lethal tile, otherwise clears to 0.
  - w_haz: same rule for Watergirl.
  - win_cnt: increments if both characters are in-door, otherwise clears. It saturates at WIN_FRAMES.
- State transitions:
  - IDLE -> PLAY on start. restart is ignored in IDLE.
  - PLAY, on frame_tick, compute fd = (f_haz+lethal_f ≥ HAZARD_FRAMES) and wd (same for Watergirl). fd&wd -> DEAD_BOTH; fd only -> DEAD_FIRE; wd only -> DEAD_WATER. Otherwise, if the next win_cnt == WIN_FRAMES -> WIN. Death has priority over win.
  - WIN / DEAD_*: hold. restart -> PLAY with f_haz, w_haz and win_cnt cleared. start is ignored.
  - start and restart are both ignored in PLAY.
- win_progress = win_cnt. It freezes at its last value in terminal states and clears on entry to PLAY.

## Timing
- Reset (async assert, sync release): game_state=IDLE, freeze=1, win_progress=0, all blocked flags 0, all counters 0.
- All outputs are registered. Values sampled on the frame_tick edge are visible the following cycle, so latency from tick to output is 1 cycle.
- A start or restart edge changes game_state the next cycle.
- frame_tick coincident with restart in a terminal state: restart wins, the counters clear, and that tick's hazard/door data is discarded. Blocked flags still update.
- frame_tick coincident with start in IDLE: enter PLAY with counters 0. That tick does not count.
- Counters never wrap: f_haz/w_haz stop at HAZARD_FRAMES because the state leaves PLAY; win_cnt saturates.
- Reset asserted mid-PLAY returns to IDLE immediately. No partial counts survive.
- Probe inputs may change on any cycle and are only sampled on frame_tick.

## Test plan
- Reset, then start pulse: game_state 0 -> 1 one cycle after start, freeze 1 -> 0. fBottom=1 on tick -> f_grounded=1 next cycle.
- PLAY, fBottom=3 for 1 tick then 0: still PLAY, f_haz back to 0. fBottom=3 for 2 consecutive ticks -> game_state=3, freeze=1.
- PLAY, wBottom=4 and fBottom=4 on two ticks -> game_state=5. Then restart -> game_state=1, win_progress=0.
- PLAY, fRight=5 and wBottom=6 for 30 ticks -> win_progress counts 1..30, game_state=2 after tick 30. A gap at tick 15 resets win_progress to 0.
- Tick where win_cnt reaches 30 and wBottom=2 on its second lethal tick: game_state=4, not 2.
- Reset pulse while game_state=1 with win_progress=12: immediately IDLE, win_progress=0, flags 0. start is ignored in PLAY, restart is ignored in IDLE.

Source files
------------

// File: rtl/collision_endgame_fsm.sv
// Per-frame game-state controller: registers probe blocked flags and decides
// death / level-complete outcomes from persistence-filtered tile codes.
//
// state      | meaning
// IDLE       | title screen, waiting for start
// PLAY       | level running, hazard and door counters active
// WIN        | both characters held their doors long enough
// DEAD_FIRE  | Fireboy stood on a lethal tile too long
// DEAD_WATER | Watergirl stood on a lethal tile too long
// DEAD_BOTH  | both died on the same frame
module collision_endgame_fsm #(
  parameter int HAZARD_FRAMES = 2,
  parameter int WIN_FRAMES    = 30
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       restart,
  input  logic [2:0] fLeft,
  input  logic [2:0] fRight,
  input  logic [2:0] fTop,
  input  logic [2:0] fBottom,
  input  logic [2:0] wLeft,
  input  logic [2:0] wRight,
  input  logic [2:0] wTop,
  input  logic [2:0] wBottom,
  output logic       f_blk_l,
  output logic       f_blk_r,
  output logic       f_blk_u,
  output logic       f_grounded,
  output logic       w_blk_l,
  output logic       w_blk_r,
  output logic       w_blk_u,
  output logic       w_grounded,
  output logic [2:0] game_state,
  output logic       freeze,
  output logic [5:0] win_progress
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_WIN        = 3'd2,
    S_DEAD_FIRE  = 3'd3,
    S_DEAD_WATER = 3'd4,
    S_DEAD_BOTH  = 3'd5
  } state_t;

  localparam logic [2:0] T_WALL  = 3'd1;
  localparam logic [2:0] T_LAVA  = 3'd2;
  localparam logic [2:0] T_POOL  = 3'd3;
  localparam logic [2:0] T_GOO   = 3'd4;
  localparam logic [2:0] T_FDOOR = 3'd5;
  localparam logic [2:0] T_WDOOR = 3'd6;

  localparam logic [4:0] HAZ_LIM = 5'(HAZARD_FRAMES);
  localparam logic [5:0] WIN_LIM = 6'(WIN_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] f_haz_q, f_haz_d;
  logic [3:0] w_haz_q, w_haz_d;
  logic [5:0] win_cnt_q, win_cnt_d;
  logic       freeze_q, freeze_d;
  logic [7:0] blk_q;

  logic       lethal_f, lethal_w, in_door_f, in_door_w;
  logic [4:0] f_haz_sum, w_haz_sum;
  logic       fd, wd;
  logic [5:0] win_nxt;

  assign lethal_f  = (fBottom == T_POOL) || (fBottom == T_GOO);
  assign lethal_w  = (wBottom == T_LAVA) || (wBottom == T_GOO);
  assign in_door_f = (fLeft == T_FDOOR) || (fRight == T_FDOOR) || (fBottom == T_FDOOR);
  assign in_door_w = (wLeft == T_WDOOR) || (wRight == T_WDOOR) || (wBottom == T_WDOOR);

  assign f_haz_sum = {1'b0, f_haz_q} + {4'b0, lethal_f};
  assign w_haz_sum = {1'b0, w_haz_q} + {4'b0, lethal_w};
  assign fd        = (f_haz_sum >= HAZ_LIM);
  assign wd        = (w_haz_sum >= HAZ_LIM);

  // win count saturates so a long door stay can never wrap back below the limit
  assign win_nxt = !(in_door_f && in_door_w) ? 6'd0 :
                   (win_cnt_q >= WIN_LIM)     ? WIN_LIM : win_cnt_q + 6'd1;

  always_comb begin
    state_d   = state_q;
    f_haz_d   = f_haz_q;
    w_haz_d   = w_haz_q;
    win_cnt_d = win_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAY;
          f_haz_d   = '0;
          w_haz_d   = '0;
          win_cnt_d = '0;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          f_haz_d   = lethal_f ? f_haz_sum[3:0] : 4'd0;
          w_haz_d   = lethal_w ? w_haz_sum[3:0] : 4'd0;
          win_cnt_d = win_nxt;
          if (fd && wd)              state_d = S_DEAD_BOTH;
          else if (fd)               state_d = S_DEAD_FIRE;
          else if (wd)               state_d = S_DEAD_WATER;
          else if (win_nxt == WIN_LIM) state_d = S_WIN;
        end
      end
      S_WIN, S_DEAD_FIRE, S_DEAD_WATER, S_DEAD_BOTH: begin
        // restart discards any coincident tick's hazard/door data
        if (restart) begin
          state_d   = S_PLAY;
          f_haz_d   = '0;
          w_haz_d   = '0;
          win_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      f_haz_q   <= '0;
      w_haz_q   <= '0;
      win_cnt_q <= '0;
      freeze_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      f_haz_q   <= f_haz_d;
      w_haz_q   <= w_haz_d;
      win_cnt_q <= win_cnt_d;
      freeze_q  <= freeze_d;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q <= '0;
    end else if (frame_tick) begin
      blk_q <= {fLeft == T_WALL, fRight == T_WALL, fTop == T_WALL, fBottom == T_WALL,
                wLeft == T_WALL, wRight == T_WALL, wTop == T_WALL, wBottom == T_WALL};
    end
  end

  assign {f_blk_l, f_blk_r, f_blk_u, f_grounded,
          w_blk_l, w_blk_r, w_blk_u, w_grounded} = blk_q;

  assign game_state   = state_q;
  assign freeze       = freeze_q;
  assign win_progress = win_cnt_q;

endmodule

// File: tb/tb_collision_endgame_fsm.sv
// Directed scoreboard bench for collision_endgame_fsm (HAZARD_FRAMES=2, WIN_FRAMES=30).
module tb_collision_endgame_fsm;

  localparam int F_STATE = 0;
  localparam int F_FRZ   = 1;
  localparam int F_WP    = 2;
  localparam int F_GND   = 3;
  localparam int F_FLAGS = 4;

  logic       vga_clk = 1'b0;
  logic       reset_n, frame_tick, start, restart;
  logic [2:0] fLeft, fRight, fTop, fBottom, wLeft, wRight, wTop, wBottom;
  logic       f_blk_l, f_blk_r, f_blk_u, f_grounded;
  logic       w_blk_l, w_blk_r, w_blk_u, w_grounded;
  logic [2:0] game_state;
  logic       freeze;
  logic [5:0] win_progress;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  collision_endgame_fsm #(.HAZARD_FRAMES(2), .WIN_FRAMES(30)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .start(start), .restart(restart),
    .fLeft(fLeft), .fRight(fRight), .fTop(fTop), .fBottom(fBottom),
    .wLeft(wLeft), .wRight(wRight), .wTop(wTop), .wBottom(wBottom),
    .f_blk_l(f_blk_l), .f_blk_r(f_blk_r), .f_blk_u(f_blk_u), .f_grounded(f_grounded),
    .w_blk_l(w_blk_l), .w_blk_r(w_blk_r), .w_blk_u(w_blk_u), .w_grounded(w_grounded),
    .game_state(game_state), .freeze(freeze), .win_progress(win_progress)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [7:0] obs(int f);
    case (f)
      F_STATE: return {5'b0, game_state};
      F_FRZ:   return {7'b0, freeze};
      F_WP:    return {2'b0, win_progress};
      F_GND:   return {7'b0, f_grounded};
      default: return {f_blk_l, f_blk_r, f_blk_u, f_grounded,
                       w_blk_l, w_blk_r, w_blk_u, w_grounded};
    endcase
  endfunction

  task automatic expect_v(string tag, int field, logic [7:0] v);
    exp_t e;
    e.tag = tag; e.field = field; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.field);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge vga_clk);
    @(negedge vga_clk);
    frame_tick = 1'b0;
    start      = 1'b0;
    restart    = 1'b0;
    drain();
  endtask

  task automatic probes(input logic [2:0] fl, fr, ft, fb, wl, wr, wt, wb);
    fLeft = fl; fRight = fr; fTop = ft; fBottom = fb;
    wLeft = wl; wRight = wr; wTop = wt; wBottom = wb;
  endtask

  task automatic expect_state(string tag, logic [2:0] s);
    expect_v(tag, F_STATE, {5'b0, s});
    expect_v({tag, "_frz"}, F_FRZ, {7'b0, (s != 3'd1)});
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; restart = 1'b0;
    probes(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge vga_clk);
    expect_state("rst_state", 3'd0);
    expect_v("rst_wp", F_WP, 8'd0);
    expect_v("rst_flags", F_FLAGS, 8'h00);
    drain();
    reset_n = 1'b1;
    @(negedge vga_clk);

    start = 1'b1;
    expect_state("start_play", 3'd1);
    cycle();

    probes(1, 0, 0, 1, 0, 0, 1, 0); frame_tick = 1'b1;
    expect_v("grounded", F_GND, 8'd1);
    expect_v("flags_tick", F_FLAGS, 8'h92);
    cycle();
    probes(0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("flags_hold", F_FLAGS, 8'h92);
    cycle();

    probes(0, 0, 0, 3, 0, 0, 0, 0); frame_tick = 1'b1;
    expect_state("haz1", 3'd1);
    expect_v("flags_clear", F_FLAGS, 8'h00);
    cycle();
    probes(0, 0, 0, 0, 0, 0, 0, 0); frame_tick = 1'b1;
    expect_state("haz_gap", 3'd1);
    cycle();
    probes(0, 0, 0, 3, 0, 0, 0, 0); frame_tick = 1'b1;
    expect_state("haz_again1", 3'd1);
    cycle();
    frame_tick = 1'b1;
    expect_state("dead_fire", 3'd3);
    cycle();

    start = 1'b1;
    expect_state("start_ign_term", 3'd3);
    cycle();
    restart = 1'b1;
    expect_state("restart_df", 3'd1);
    expect_v("restart_df_wp", F_WP, 8'd0);
    cycle();

    probes(0, 0, 0, 4, 0, 0, 0, 4); frame_tick = 1'b1;
    expect_state("both1", 3'd1);
    cycle();
    frame_tick = 1'b1;
    expect_state("dead_both", 3'd5);
    cycle();

    probes(1, 0, 0, 4, 0, 0, 0, 4); frame_tick = 1'b1; restart = 1'b1;
    expect_state("restart_tick", 3'd1);
    expect_v("restart_tick_wp", F_WP, 8'd0);
    expect_v("restart_tick_flags", F_FLAGS, 8'h80);
    cycle();
    frame_tick = 1'b1;
    expect_state("restart_discard", 3'd1);
    cycle();
    probes(0, 0, 0, 0, 0, 0, 0, 0); frame_tick = 1'b1;
    expect_state("clear_haz", 3'd1);
    cycle();

    for (int i = 1; i <= 14; i++) begin
      probes(0, 5, 0, 0, 0, 0, 0, 6); frame_tick = 1'b1;
      expect_v($sformatf("win_a%0d", i), F_WP, 8'(i));
      cycle();
    end
    probes(0, 0, 0, 0, 0, 0, 0, 0); frame_tick = 1'b1;
    expect_v("win_gap", F_WP, 8'd0);
    expect_state("win_gap_state", 3'd1);
    cycle();
    for (int i = 1; i <= 30; i++) begin
      probes(0, 5, 0, 0, 0, 0, 0, 6); frame_tick = 1'b1;
      expect_v($sformatf("win_b%0d", i), F_WP, 8'(i));
      expect_state($sformatf("win_b%0d_st", i), (i == 30) ? 3'd2 : 3'd1);
      cycle();
    end
    expect_state("win_hold", 3'd2);
    expect_v("win_hold_wp", F_WP, 8'd30);
    cycle();
    restart = 1'b1;
    expect_state("restart_win", 3'd1);
    expect_v("restart_win_wp", F_WP, 8'd0);
    cycle();

    for (int i = 1; i <= 28; i++) begin
      probes(0, 5, 0, 0, 0, 0, 0, 6); frame_tick = 1'b1;
      cycle();
    end
    probes(0, 5, 0, 0, 6, 0, 0, 2); frame_tick = 1'b1;
    expect_v("prio_wp29", F_WP, 8'd29);
    expect_state("prio_29", 3'd1);
    cycle();
    frame_tick = 1'b1;
    expect_state("prio_death", 3'd4);
    expect_v("prio_wp30", F_WP, 8'd30);
    cycle();
    restart = 1'b1;
    expect_state("restart_dw", 3'd1);
    cycle();

    for (int i = 1; i <= 12; i++) begin
      probes((i == 12) ? 3'd1 : 3'd0, 5, 0, 0, 0, 0, 0, 6); frame_tick = 1'b1;
      cycle();
    end
    expect_v("mid_wp12", F_WP, 8'd12);
    expect_v("mid_flags", F_FLAGS, 8'h80);
    drain();
    start = 1'b1;
    expect_state("start_ign_play", 3'd1);
    expect_v("start_ign_wp", F_WP, 8'd12);
    cycle();

    #2 reset_n = 1'b0;
    #1;
    expect_state("async_rst", 3'd0);
    expect_v("async_rst_wp", F_WP, 8'd0);
    expect_v("async_rst_flags", F_FLAGS, 8'h00);
    drain();
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);

    restart = 1'b1;
    expect_state("restart_ign_idle", 3'd0);
    cycle();

    probes(0, 5, 0, 0, 0, 0, 0, 6); frame_tick = 1'b1; start = 1'b1;
    expect_state("start_tick", 3'd1);
    expect_v("start_tick_wp", F_WP, 8'd0);
    cycle();
    frame_tick = 1'b1;
    expect_v("start_tick_next_wp", F_WP, 8'd1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
